// File: rtl/lane_rr_scheduler_pkg.sv
// Shared widths, lane index type and index-width helper for the lane round-robin scheduler.
package lane_sched_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_IDX_W  = idx_w(DEF_N_REQ);

  typedef logic [DEF_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/lane_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted req after 'last', wrapping modulo N_REQ.
module rr_pick
  import lane_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] pos;
  logic             found;

  // Walk N_REQ positions starting just after 'last'; the final step revisits 'last' itself.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = last;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = (pos == IDX_W'(N_REQ - 1)) ? '0 : pos + IDX_W'(1);
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/lane_rr_scheduler.sv
// Round-robin scheduler sharing one registered lane output stage among N_REQ requesters.
module lane_rr_scheduler
  import lane_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_lane,
  input  logic                      out_ready
);

  logic              can_load_c;
  logic              pick_en_c;
  logic              xfer_c;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic [DATA_W-1:0] sel_data_c;
  logic [IDX_W-1:0]  last_grant;

  // Load when the register is empty or being drained this cycle; never during reset.
  assign can_load_c = !out_valid || out_ready;
  assign pick_en_c  = can_load_c && !rst;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_valid),
    .last    (last_grant),
    .en      (pick_en_c),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx_c)
  );

  assign xfer_c = |req_ready;

  // One-hot AND-OR mux keeps the grant path independent of req_data.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel_data_c = sel_data_c | (req_data[k*DATA_W +: DATA_W] & {DATA_W{req_ready[k]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_lane   <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
    end else if (xfer_c) begin
      out_valid  <= 1'b1;
      out_data   <= sel_data_c;
      out_lane   <= gnt_idx_c;
      last_grant <= gnt_idx_c;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Directed self-checking bench for lane_rr_scheduler (N_REQ=4, DATA_W=4).
module tb_lane_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_lane;
  logic        out_ready;

  int n_cmp;
  int n_err;

  lane_rr_scheduler #(.N_REQ(4), .DATA_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_data = 16'h4321; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if (out_lane !== 2'd0) begin n_err++; $display("FAIL reset_lane: got %0d want 0", out_lane); end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_data = 16'h0A00; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 4'hA) begin n_err++; $display("FAIL single_data: got %h want a", out_data); end
    n_cmp++; if (out_lane !== 2'd2) begin n_err++; $display("FAIL single_lane: got %0d want 2", out_lane); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_all_lanes();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_dat [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    logic [1:0] exp_ln  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_valid = 4'b1111; req_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (req_ready !== exp_gnt[i]) begin n_err++; $display("FAIL all_ready[%0d]: got %b want %b", i, req_ready, exp_gnt[i]); end
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL all_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== exp_dat[i]) begin n_err++; $display("FAIL all_data[%0d]: got %h want %h", i, out_data, exp_dat[i]); end
      n_cmp++; if (out_lane !== exp_ln[i]) begin n_err++; $display("FAIL all_lane[%0d]: got %0d want %0d", i, out_lane, exp_ln[i]); end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001; req_data = 16'h0005; out_ready = 1'b1;
    step();
    out_ready = 1'b0; req_valid = 4'b1010; req_data = 16'h7060;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); end
      step();
      n_cmp++; if (out_data !== 4'h5 || out_valid !== 1'b1 || out_lane !== 2'd0)
        begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%0d want v=1 d=5 l=0", i, out_valid, out_data, out_lane); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
    step();
    n_cmp++; if (out_data !== 4'h6 || out_lane !== 2'd1 || out_valid !== 1'b1)
      begin n_err++; $display("FAIL bp_release_out: got v=%b d=%h l=%0d want v=1 d=6 l=1", out_valid, out_data, out_lane); end
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_next_ready: got %b want 1000", req_ready); end
    step();
    n_cmp++; if (out_data !== 4'h7 || out_lane !== 2'd3)
      begin n_err++; $display("FAIL bp_next_out: got d=%h l=%0d want d=7 l=3", out_data, out_lane); end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    req_valid = 4'b1000; req_data = 16'h8000; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_self_ready: got %b want 1000", req_ready); end
    step();
    n_cmp++; if (out_data !== 4'h8 || out_lane !== 2'd3)
      begin n_err++; $display("FAIL wrap_self_out: got d=%h l=%0d want d=8 l=3", out_data, out_lane); end
    req_valid = 4'b1001; req_data = 16'h8009;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_zero_ready: got %b want 0001", req_ready); end
    step();
    n_cmp++; if (out_data !== 4'h9 || out_lane !== 2'd0)
      begin n_err++; $display("FAIL wrap_zero_out: got d=%h l=%0d want d=9 l=0", out_data, out_lane); end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_data = 16'h0B00; out_ready = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_lane !== 2'd2)
      begin n_err++; $display("FAIL mid_load: got v=%b l=%0d want v=1 l=2", out_valid, out_lane); end
    rst = 1'b1; req_valid = 4'b1111; req_data = 16'h4321;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_lane !== 2'd0 || out_data !== 4'h0)
      begin n_err++; $display("FAIL mid_rst_out: got v=%b d=%h l=%0d want v=0 d=0 l=0", out_valid, out_data, out_lane); end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_ready: got %b want 0001", req_ready); end
    step();
    n_cmp++; if (out_data !== 4'h1 || out_lane !== 2'd0)
      begin n_err++; $display("FAIL mid_first_out: got d=%h l=%0d want d=1 l=0", out_data, out_lane); end
    req_valid = '0;
  endtask

  task automatic test_idle();
    req_valid = 4'b0100; req_data = 16'h0C00; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL idle_grant_ready: got %b want 0100", req_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== 4'hC)
      begin n_err++; $display("FAIL idle_grant_out: got v=%b d=%h l=%0d want v=1 d=c l=2", out_valid, out_data, out_lane); end
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0 || out_data !== 4'hC || out_lane !== 2'd2)
        begin n_err++; $display("FAIL idle_hold[%0d]: got v=%b d=%h l=%0d want v=0 d=c l=2", i, out_valid, out_data, out_lane); end
    end
    req_valid = 4'b1001; req_data = 16'hD00E;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL idle_next_ready: got %b want 1000", req_ready); end
    step();
    n_cmp++; if (out_data !== 4'hD || out_lane !== 2'd3)
      begin n_err++; $display("FAIL idle_next_out: got d=%h l=%0d want d=d l=3", out_data, out_lane); end
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL idle_after_ready: got %b want 0001", req_ready); end
    step();
    n_cmp++; if (out_data !== 4'hE || out_lane !== 2'd0)
      begin n_err++; $display("FAIL idle_after_out: got d=%h l=%0d want d=e l=0", out_data, out_lane); end
    req_valid = '0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_all_lanes();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
